// File: rtl/tpu_tile_sched.sv
// Tile scheduler for the systolic array: walks C = A x B in ARR x ARR tiles and drives
// gbuff read addresses, array controls and output-buffer writes; every output is registered.
module tpu_tile_sched #(
   parameter int ARR = 4,
   parameter int AW  = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [4:0]    m,
   input  logic [4:0]    n,
   input  logic [4:0]    k,
   output logic          busy,
   output logic          done,
   output logic          a_rd_en,
   output logic          b_rd_en,
   output logic [AW-1:0] a_addr,
   output logic [AW-1:0] b_addr,
   output logic          arr_clr,
   output logic          arr_en,
   output logic          arr_in_valid,
   output logic          out_wr_en,
   output logic [AW-1:0] out_addr
);

   localparam int LG = $clog2(ARR);
   localparam int CW = $clog2(2 * ARR + 32);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DRAIN, S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [4:0]      k_q, k_d;
   logic [4:0]      mt_num_q, mt_num_d;
   logic [4:0]      nt_num_q, nt_num_d;
   logic [4:0]      mt_q, mt_d;
   logic [4:0]      nt_q, nt_d;

   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            rd_en_q, rd_en_d;
   logic [AW-1:0]   a_addr_q, a_addr_d;
   logic [AW-1:0]   b_addr_q, b_addr_d;
   logic            arr_clr_q, arr_clr_d;
   logic            arr_en_q, arr_en_d;
   logic            in_valid_q, in_valid_d;
   logic            wr_en_q, wr_en_d;
   logic [AW-1:0]   out_addr_q, out_addr_d;

   function automatic logic [4:0] tiles(input logic [4:0] d);
      logic [5:0] s;
      s = {1'b0, d} + 6'(ARR - 1);
      return 5'(s >> LG);
   endfunction

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      k_d      = k_q;
      mt_num_d = mt_num_q;
      nt_num_d = nt_num_q;
      mt_d     = mt_q;
      nt_d     = nt_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               k_d      = k;
               mt_num_d = tiles(m);
               nt_num_d = tiles(n);
               mt_d     = '0;
               nt_d     = '0;
               cnt_d    = '0;
               state_d  = (m == '0 || n == '0 || k == '0) ? S_DONE : S_CLEAR;
            end
         end
         S_CLEAR: begin
            cnt_d   = '0;
            state_d = S_FEED;
         end
         S_FEED: begin
            if (cnt_q == CW'(k_q) - CW'(1)) begin
               cnt_d   = '0;
               state_d = S_FLUSH;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_FLUSH: begin
            if (cnt_q == CW'(2 * ARR - 2)) begin
               cnt_d   = '0;
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DRAIN: begin
            if (cnt_q == CW'(ARR - 1)) begin
               cnt_d   = '0;
               state_d = S_CLEAR;
               // nt is the inner loop; the job ends after the last nt of the last mt
               if (nt_q == nt_num_q - 5'd1) begin
                  nt_d = '0;
                  if (mt_q == mt_num_q - 5'd1) begin
                     state_d = S_DONE;
                  end else begin
                     mt_d = mt_q + 5'd1;
                  end
               end else begin
                  nt_d = nt_q + 5'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they register in step with it.
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
      rd_en_d    = (state_d == S_FEED);
      arr_clr_d  = (state_d == S_CLEAR);
      arr_en_d   = (state_d == S_FEED) || (state_d == S_FLUSH);
      wr_en_d    = (state_d == S_DRAIN);
      in_valid_d = rd_en_q;
      a_addr_d   = '0;
      b_addr_d   = '0;
      out_addr_d = '0;
      if (rd_en_d) begin
         a_addr_d = AW'(mt_d) * AW'(k_d) + AW'(cnt_d);
         b_addr_d = AW'(nt_d) * AW'(k_d) + AW'(cnt_d);
      end
      if (wr_en_d) begin
         out_addr_d = ((AW'(mt_d) * AW'(nt_num_d) + AW'(nt_d)) << LG) + AW'(cnt_d);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         k_q        <= '0;
         mt_num_q   <= '0;
         nt_num_q   <= '0;
         mt_q       <= '0;
         nt_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_en_q    <= 1'b0;
         a_addr_q   <= '0;
         b_addr_q   <= '0;
         arr_clr_q  <= 1'b0;
         arr_en_q   <= 1'b0;
         in_valid_q <= 1'b0;
         wr_en_q    <= 1'b0;
         out_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         k_q        <= k_d;
         mt_num_q   <= mt_num_d;
         nt_num_q   <= nt_num_d;
         mt_q       <= mt_d;
         nt_q       <= nt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_en_q    <= rd_en_d;
         a_addr_q   <= a_addr_d;
         b_addr_q   <= b_addr_d;
         arr_clr_q  <= arr_clr_d;
         arr_en_q   <= arr_en_d;
         in_valid_q <= in_valid_d;
         wr_en_q    <= wr_en_d;
         out_addr_q <= out_addr_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign a_rd_en      = rd_en_q;
   assign b_rd_en      = rd_en_q;
   assign a_addr       = a_addr_q;
   assign b_addr       = b_addr_q;
   assign arr_clr      = arr_clr_q;
   assign arr_en       = arr_en_q;
   assign arr_in_valid = in_valid_q;
   assign out_wr_en    = wr_en_q;
   assign out_addr     = out_addr_q;

endmodule

// File: tb/tb_tpu_tile_sched.sv
// Self-checking bench for tpu_tile_sched: directed and random jobs against a tile-walk model.
module tb_tpu_tile_sched;

   localparam int ARR = 4;
   localparam int AW  = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [4:0]    m = '0, n = '0, k = '0;
   logic          busy, done, a_rd_en, b_rd_en, arr_clr, arr_en, arr_in_valid, out_wr_en;
   logic [AW-1:0] a_addr, b_addr, out_addr;

   int tests = 0;
   int fails = 0;

   typedef struct {
      bit busy, done, rd, clr, en, iv, wr;
      int a, b, o;
   } rec_t;

   rec_t exp_q[$];

   tpu_tile_sched #(.ARR(ARR), .AW(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .m(m), .n(n), .k(k),
      .busy(busy), .done(done), .a_rd_en(a_rd_en), .b_rd_en(b_rd_en),
      .a_addr(a_addr), .b_addr(b_addr), .arr_clr(arr_clr), .arr_en(arr_en),
      .arr_in_valid(arr_in_valid), .out_wr_en(out_wr_en), .out_addr(out_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      if (obs !== expv) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic rec_t blank();
      rec_t r;
      r.busy = 0; r.done = 0; r.rd = 0; r.clr = 0; r.en = 0; r.iv = 0; r.wr = 0;
      r.a = 0; r.b = 0; r.o = 0;
      return r;
   endfunction

   task automatic cmp(input rec_t e, input string ph);
      chk({"busy@", ph},  32'(busy),         32'(e.busy));
      chk({"done@", ph},  32'(done),         32'(e.done));
      chk({"a_rd@", ph},  32'(a_rd_en),      32'(e.rd));
      chk({"b_rd@", ph},  32'(b_rd_en),      32'(e.rd));
      chk({"clr@", ph},   32'(arr_clr),      32'(e.clr));
      chk({"en@", ph},    32'(arr_en),       32'(e.en));
      chk({"iv@", ph},    32'(arr_in_valid), 32'(e.iv));
      chk({"wr@", ph},    32'(out_wr_en),    32'(e.wr));
      chk({"a_addr@", ph}, 32'(a_addr),      32'(e.a));
      chk({"b_addr@", ph}, 32'(b_addr),      32'(e.b));
      chk({"o_addr@", ph}, 32'(out_addr),    32'(e.o));
   endtask

   // Expected per-cycle outputs, first entry = cycle right after the start-sampling edge.
   task automatic build(input int mm, input int nn, input int kk);
      rec_t r;
      int mtn, ntn;
      exp_q.delete();
      if (mm == 0 || nn == 0 || kk == 0) begin
         r = blank(); r.busy = 1; r.done = 1;
         exp_q.push_back(r);
         return;
      end
      mtn = (mm + ARR - 1) / ARR;
      ntn = (nn + ARR - 1) / ARR;
      for (int mt = 0; mt < mtn; mt++) begin
         for (int nt = 0; nt < ntn; nt++) begin
            r = blank(); r.busy = 1; r.clr = 1;
            exp_q.push_back(r);
            for (int i = 0; i < kk; i++) begin
               r = blank(); r.busy = 1; r.rd = 1; r.en = 1;
               r.a = mt * kk + i; r.b = nt * kk + i;
               exp_q.push_back(r);
            end
            for (int f = 0; f < 2 * ARR - 1; f++) begin
               r = blank(); r.busy = 1; r.en = 1;
               exp_q.push_back(r);
            end
            for (int rr = 0; rr < ARR; rr++) begin
               r = blank(); r.busy = 1; r.wr = 1; r.o = (mt * ntn + nt) * ARR + rr;
               exp_q.push_back(r);
            end
         end
      end
      r = blank(); r.busy = 1; r.done = 1;
      exp_q.push_back(r);
      for (int i = exp_q.size() - 1; i > 0; i--) exp_q[i].iv = exp_q[i-1].rd;
   endtask

   // sb: trace index after which a stray start is pulsed; ra: trace index after which rst hits.
   task automatic run_job(input string name, input int mm, input int nn, input int kk,
                          input int sb, input int ra);
      int len;
      build(mm, nn, kk);
      len = exp_q.size();
      @(negedge clk);
      start = 1'b1; m = 5'(mm); n = 5'(nn); k = 5'(kk);
      for (int i = 0; i < len; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
         m = 5'($urandom_range(0, 31)); n = 5'($urandom_range(0, 31)); k = 5'($urandom_range(0, 31));
         cmp(exp_q[i], $sformatf("%s.%0d", name, i));
         if (i == sb) start = 1'b1;
         if (i == ra) begin
            start = 1'b0;
            #1 rst = 1'b1;
            #1 cmp(blank(), $sformatf("%s.rst", name));
            repeat (4) begin
               @(posedge clk); #1;
               cmp(blank(), $sformatf("%s.rsthold", name));
            end
            rst = 1'b0;
            repeat (3) begin
               @(posedge clk); #1;
               cmp(blank(), $sformatf("%s.postrst", name));
            end
            return;
         end
      end
      @(posedge clk); #1;
      cmp(blank(), $sformatf("%s.idle", name));
   endtask

   initial begin
      #12;
      cmp(blank(), "reset");
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      cmp(blank(), "idle0");

      run_job("single", 4, 4, 4, -1, -1);
      chk("single_len", exp_q.size(), 17);
      run_job("multi", 8, 8, 3, -1, -1);
      chk("multi_len", exp_q.size(), 61);
      run_job("ragged", 5, 3, 1, -1, -1);
      chk("ragged_len", exp_q.size(), 27);
      run_job("zero_k", 4, 4, 0, -1, -1);
      run_job("zero_m", 0, 7, 9, -1, -1);
      run_job("busy_start", 4, 4, 4, 2, -1);
      run_job("rst_mid", 8, 8, 3, -1, 12);
      run_job("after_rst", 4, 4, 4, -1, -1);
      run_job("max", 31, 31, 31, -1, -1);

      for (int j = 0; j < 10; j++) begin
         int mm, nn, kk, len, sb;
         mm = $urandom_range(0, 14);
         nn = $urandom_range(0, 14);
         kk = $urandom_range(0, 12);
         build(mm, nn, kk);
         len = exp_q.size();
         sb = (j % 2 == 0) ? $urandom_range(0, len - 1) : -1;
         run_job($sformatf("rnd%0d", j), mm, nn, kk, sb, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
